// File: rtl/control_pkg.sv
// control_pkg: shared types and select encodings for the multicycle main
// controller (control_fsm) and its wait timer.
//   state_t       - controller state, encoding also exported on the State port
//   IC_*          - InstrClass decode values
//   ADR_*         - AdrSrc selects
//   SRCB_*        - ALUSrcB selects
//   RES_*         - ResultSrc selects
//   is_wait_state - states that hold a memory request open and may stall
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FAULT  = 4'd10
  } state_t;

  localparam logic [1:0] IC_DP  = 2'b00;
  localparam logic [1:0] IC_MEM = 2'b01;
  localparam logic [1:0] IC_BR  = 2'b10;
  localparam logic [1:0] IC_ILL = 2'b11;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // States that wait on MemReady and therefore feed the stall timer.
  function automatic logic is_wait_state(input state_t s);
    logic w;
    case (s)
      S_FETCH, S_MEMRD, S_MEMWR: w = 1'b1;
      default:                   w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts consecutive stalled memory-wait cycles and flags when the
// current stalled cycle is the last one allowed.
//   clk, rst  - clock, synchronous active-high reset
//   count_en  - this cycle is a stalled wait cycle
//   clear     - restart the count (ready seen, or not in a wait state)
//   expired   - stalled cycle number TIMEOUT is happening now; never with TIMEOUT=0
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  // A zero-width counter is illegal, so the disabled case keeps one bit.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_r;

  // Stall counter; clear has priority so a ready cycle always restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (count_en) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign expired = count_en && (cnt_r == CW'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle main controller. Walks each instruction through
// fetch/decode/execute/memory/writeback and emits raw write intents (PCS, RegW,
// MemW, FlagW) for conditional_logic, datapath mux selects and the memory
// request handshake. A stalled memory wait longer than TIMEOUT cycles, an
// illegal class or a disabled vector instruction parks the FSM in FAULT until rst.
//   clk, rst           - clock, synchronous active-high reset
//   InstrClass, Imm,
//   L, S, V            - instruction fields, decoded in DECODE
//   MemReady           - memory completes the current access this cycle
//   MemReq, IRWrite,
//   AdrSrc, ALUSrcA,
//   ALUSrcB, ResultSrc,
//   ALUOp, VecOp       - datapath controls
//   PCS, RegW, MemW,
//   FlagW              - write intents, gated later by CondEx
//   Fault              - sticky fault indicator
//   State              - current state, debug
module control_fsm
  import control_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter bit VEC_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] InstrClass,
  input  logic       Imm,
  input  logic       L,
  input  logic       S,
  input  logic       V,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       VecOp,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       Fault,
  output logic [3:0] State
);

  state_t state_r;
  state_t next_s;
  logic   v_r;
  logic   count_en_s;
  logic   clear_s;
  logic   expired_s;

  assign count_en_s = is_wait_state(state_r) && !MemReady;
  assign clear_s    = !count_en_s;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .count_en (count_en_s),
    .clear    (clear_s),
    .expired  (expired_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Vector bit captured at decode so ALUWB still knows the lane mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      v_r <= V;
    end else begin
      v_r <= v_r;
    end
  end

  // Next-state logic; a timeout beats staying, MemReady beats a timeout.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (MemReady) begin
          next_s = S_DECODE;
        end else if (expired_s) begin
          next_s = S_FAULT;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (InstrClass == IC_ILL) begin
          next_s = S_FAULT;
        end else if (V && !VEC_EN) begin
          next_s = S_FAULT;
        end else begin
          case (InstrClass)
            IC_DP:   next_s = Imm ? S_EXECI : S_EXECR;
            IC_MEM:  next_s = S_MEMADR;
            IC_BR:   next_s = S_BRANCH;
            default: next_s = S_FAULT;
          endcase
        end
      end
      S_MEMADR: next_s = L ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (MemReady) begin
          next_s = S_MEMWB;
        end else if (expired_s) begin
          next_s = S_FAULT;
        end else begin
          next_s = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (MemReady) begin
          next_s = S_FETCH;
        end else if (expired_s) begin
          next_s = S_FAULT;
        end else begin
          next_s = S_MEMWR;
        end
      end
      S_MEMWB, S_ALUWB, S_BRANCH: next_s = S_FETCH;
      S_EXECR, S_EXECI:           next_s = S_ALUWB;
      S_FAULT:                    next_s = S_FAULT;
      default:                    next_s = S_FAULT;
    endcase
  end

  // Output decode from the registered state; MemReady only qualifies the
  // fetch-completion strobes and the single-cycle store write.
  always_comb begin
    MemReq    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = ADR_PC;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    ALUOp     = 1'b0;
    VecOp     = 1'b0;
    PCS       = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    FlagW     = 2'b00;
    Fault     = 1'b0;
    case (state_r)
      S_FETCH: begin
        MemReq    = 1'b1;
        AdrSrc    = ADR_PC;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCS       = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = ADR_ALUOUT;
      end
      S_MEMWB: begin
        RegW      = 1'b1;
        ResultSrc = RES_MEMDATA;
      end
      S_MEMWR: begin
        MemReq = 1'b1;
        AdrSrc = ADR_ALUOUT;
        MemW   = MemReady;
      end
      S_EXECR: begin
        ALUSrcB = SRCB_REG;
        ALUOp   = 1'b1;
        FlagW   = {S, S};
        VecOp   = V && VEC_EN;
      end
      S_EXECI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
        FlagW   = {S, S};
        VecOp   = V && VEC_EN;
      end
      S_ALUWB: begin
        RegW      = 1'b1;
        ResultSrc = RES_ALUOUT;
        VecOp     = v_r && VEC_EN;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCS       = 1'b1;
      end
      S_FAULT: Fault = 1'b1;
      default: Fault = 1'b1;
    endcase
  end

  assign State = state_r;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed scoreboard bench for control_fsm. dut_a runs with
// TIMEOUT=4, VEC_EN=0; dut_b runs with TIMEOUT=15, VEC_EN=1 on the same inputs
// and is only checked in the vector sequence.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] InstrClass;
  logic       Imm, L, S, V, MemReady;

  logic       a_MemReq, a_IRWrite, a_AdrSrc, a_ALUSrcA, a_ALUOp, a_VecOp;
  logic       a_PCS, a_RegW, a_MemW, a_Fault;
  logic [1:0] a_ALUSrcB, a_ResultSrc, a_FlagW;
  logic [3:0] a_State;
  logic       b_MemReq, b_IRWrite, b_AdrSrc, b_ALUSrcA, b_ALUOp, b_VecOp;
  logic       b_PCS, b_RegW, b_MemW, b_Fault;
  logic [1:0] b_ALUSrcB, b_ResultSrc, b_FlagW;
  logic [3:0] b_State;

  always #5 clk = ~clk;

  control_fsm #(.TIMEOUT(4), .VEC_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .InstrClass(InstrClass), .Imm(Imm), .L(L), .S(S),
    .V(V), .MemReady(MemReady), .MemReq(a_MemReq), .IRWrite(a_IRWrite),
    .AdrSrc(a_AdrSrc), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
    .ResultSrc(a_ResultSrc), .ALUOp(a_ALUOp), .VecOp(a_VecOp), .PCS(a_PCS),
    .RegW(a_RegW), .MemW(a_MemW), .FlagW(a_FlagW), .Fault(a_Fault),
    .State(a_State)
  );

  control_fsm #(.TIMEOUT(15), .VEC_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .InstrClass(InstrClass), .Imm(Imm), .L(L), .S(S),
    .V(V), .MemReady(MemReady), .MemReq(b_MemReq), .IRWrite(b_IRWrite),
    .AdrSrc(b_AdrSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
    .ResultSrc(b_ResultSrc), .ALUOp(b_ALUOp), .VecOp(b_VecOp), .PCS(b_PCS),
    .RegW(b_RegW), .MemW(b_MemW), .FlagW(b_FlagW), .Fault(b_Fault),
    .State(b_State)
  );

  // Packed view: State, Fault, MemReq, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
  // ResultSrc, ALUOp, VecOp, PCS, RegW, MemW, FlagW.
  wire [19:0] obs_a = {a_State, a_Fault, a_MemReq, a_IRWrite, a_AdrSrc, a_ALUSrcA,
                       a_ALUSrcB, a_ResultSrc, a_ALUOp, a_VecOp, a_PCS, a_RegW,
                       a_MemW, a_FlagW};
  wire [19:0] obs_b = {b_State, b_Fault, b_MemReq, b_IRWrite, b_AdrSrc, b_ALUSrcA,
                       b_ALUSrcB, b_ResultSrc, b_ALUOp, b_VecOp, b_PCS, b_RegW,
                       b_MemW, b_FlagW};

  localparam logic [19:0] M_ALL = 20'hFFFFF;
  // During reset: State, Fault, MemReq, IRWrite, ALUSrcB, PCS, RegW, MemW, FlagW.
  localparam logic [19:0] M_RST = 20'hFE61F;

  typedef struct {
    string       tag;
    bit          which;
    logic [19:0] exp;
    logic [19:0] mask;
  } rec_t;

  rec_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Expected outputs for a state, straight from the per-state output table.
  function automatic logic [19:0] exp_out(input logic [3:0] st, input logic mr,
                                          input logic s, input logic vec);
    logic       flt, mreq, irw, adr, srca, aop, vop, pcs, regw, memw;
    logic [1:0] srcb, res, fw;
    flt = 1'b0; mreq = 1'b0; irw = 1'b0; adr = 1'b0; srca = 1'b0; aop = 1'b0;
    vop = 1'b0; pcs = 1'b0; regw = 1'b0; memw = 1'b0;
    srcb = 2'b00; res = 2'b00; fw = 2'b00;
    case (st)
      4'd0:  begin mreq = 1'b1; srca = 1'b1; srcb = 2'b10; res = 2'b10; irw = mr; pcs = mr; end
      4'd1:  begin srca = 1'b1; srcb = 2'b10; res = 2'b10; end
      4'd2:  srcb = 2'b01;
      4'd3:  begin mreq = 1'b1; adr = 1'b1; end
      4'd4:  begin regw = 1'b1; res = 2'b01; end
      4'd5:  begin mreq = 1'b1; adr = 1'b1; memw = mr; end
      4'd6:  begin aop = 1'b1; fw = {s, s}; vop = vec; end
      4'd7:  begin srcb = 2'b01; aop = 1'b1; fw = {s, s}; vop = vec; end
      4'd8:  begin regw = 1'b1; vop = vec; end
      4'd9:  begin srcb = 2'b01; res = 2'b10; pcs = 1'b1; end
      4'd10: flt = 1'b1;
      default: flt = 1'bx;
    endcase
    return {st, flt, mreq, irw, adr, srca, srcb, res, aop, vop, pcs, regw, memw, fw};
  endfunction

  // Push expectations for this cycle, compare mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic [3:0] st_a, input logic [19:0] mask_a,
                      input bit chk_b, input logic [3:0] st_b, input logic vec_b);
    rec_t        r;
    logic [19:0] o;
    r.tag = tag; r.which = 1'b0; r.exp = exp_out(st_a, MemReady, S, 1'b0); r.mask = mask_a;
    sb.push_back(r);
    if (chk_b) begin
      r.tag = {tag, "_vec"}; r.which = 1'b1; r.exp = exp_out(st_b, MemReady, S, vec_b);
      r.mask = M_ALL;
      sb.push_back(r);
    end
    #2;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      o = r.which ? obs_b : obs_a;
      vectors++;
      assert ((o & r.mask) === (r.exp & r.mask)) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", r.tag, o & r.mask, r.exp & r.mask);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic s1(input string tag, input logic [3:0] st);
    step(tag, st, M_ALL, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic drive(input logic [1:0] ic, input logic imm, input logic l,
                       input logic s, input logic v, input logic mr);
    InstrClass = ic; Imm = imm; L = l; S = s; V = v; MemReady = mr;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    step("rst_init0", 4'd0, M_RST, 1'b0, 4'd0, 1'b0);
    step("rst_init1", 4'd0, M_RST, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;

    // Data-processing, register operand, S=1.
    drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    s1("dp_fetch", 4'd0); s1("dp_decode", 4'd1); s1("dp_execr", 4'd6); s1("dp_aluwb", 4'd8);

    // Data-processing, immediate operand, S=0.
    drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    s1("dpi_fetch", 4'd0); s1("dpi_decode", 4'd1); s1("dpi_execi", 4'd7); s1("dpi_aluwb", 4'd8);

    // Load with three stalled MEMRD cycles.
    drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    s1("ld_fetch", 4'd0); s1("ld_decode", 4'd1); s1("ld_memadr", 4'd2);
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) s1("ld_stall", 4'd3);
    MemReady = 1'b1;
    s1("ld_ready", 4'd3); s1("ld_memwb", 4'd4);

    // Store, ready on the second MEMWR cycle.
    drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    s1("st_fetch", 4'd0); s1("st_decode", 4'd1); s1("st_memadr", 4'd2);
    MemReady = 1'b0; s1("st_wait", 4'd5);
    MemReady = 1'b1; s1("st_write", 4'd5);
    MemReady = 1'b0; s1("st_done", 4'd0);

    // Reset applied for two cycles in the middle of a load.
    drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    s1("rm_fetch", 4'd0); s1("rm_decode", 4'd1); s1("rm_memadr", 4'd2);
    MemReady = 1'b0; s1("rm_stall", 4'd3);
    rst = 1'b1; s1("rm_rst_edge", 4'd3);
    step("rm_rst0", 4'd0, M_RST, 1'b0, 4'd0, 1'b0);
    step("rm_rst1", 4'd0, M_RST, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;

    // Fetch stall timeout: four stalled cycles then a sticky FAULT.
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) s1("to_stall", 4'd0);
    for (int i = 0; i < 20; i++) begin
      MemReady = 1'($urandom_range(0, 1));
      s1("to_fault_hold", 4'd10);
    end
    rst = 1'b1; MemReady = 1'b0;
    s1("to_rst_edge", 4'd10);
    step("to_cleared", 4'd0, M_RST, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;

    // Ready on the fourth stalled cycle wins over the timeout; then a branch.
    drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) s1("nf_stall", 4'd0);
    MemReady = 1'b1;
    s1("nf_ready", 4'd0); s1("br_decode", 4'd1); s1("br_branch", 4'd9); s1("br_fetch", 4'd0);

    // Illegal class from DECODE.
    InstrClass = 2'b11;
    s1("il_decode", 4'd1); s1("il_fault", 4'd10);
    rst = 1'b1; s1("il_rst_edge", 4'd10);
    step("il_cleared", 4'd0, M_RST, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;

    // Vector op: faults with VEC_EN=0, runs with lanes enabled when VEC_EN=1;
    // V drops in ALUWB to show the decoded bit is held.
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("vx_fetch", 4'd0, M_ALL, 1'b1, 4'd0, 1'b0);
    step("vx_decode", 4'd1, M_ALL, 1'b1, 4'd1, 1'b0);
    step("vx_exec", 4'd10, M_ALL, 1'b1, 4'd6, 1'b1);
    V = 1'b0;
    step("vx_aluwb", 4'd10, M_ALL, 1'b1, 4'd8, 1'b1);
    step("vx_next", 4'd10, M_ALL, 1'b1, 4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
